// File: rtl/pix_interp_pkg.sv
// Shared sizing helpers for the sub-pixel interpolator pipeline.
package pix_interp_pkg;

  function automatic int taps_f(input int sel_w);
    return (1 << sel_w) + 1;
  endfunction

  function automatic int wgt_one_f(input int sub_w);
    return 1 << sub_w;
  endfunction

  function automatic int half_f(input int sub_w);
    return 1 << (sub_w - 1);
  endfunction

  // Products and their sum share this width; a*(ONE-f)+b*f+HALF never overflows it.
  function automatic int sum_w_f(input int data_w, input int sub_w);
    return data_w + sub_w + 1;
  endfunction

endpackage

// File: rtl/interp_lane.sv
// One channel: tap-pair select, weighted multiply, then round/shift/clamp.
// All three stages advance together on en.
module interp_lane
  import pix_interp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 1,
  parameter int SUB_W  = 5,
  parameter int ROUND  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic [taps_f(SEL_W)*DATA_W-1:0]      i_taps,
  input  logic [SEL_W+SUB_W-1:0]               i_pos,
  output logic [DATA_W-1:0]                    o_data
);
  localparam int TAPS    = taps_f(SEL_W);
  localparam int SUM_W   = sum_w_f(DATA_W, SUB_W);
  localparam int WGT_ONE = wgt_one_f(SUB_W);
  localparam int RND     = (ROUND != 0) ? half_f(SUB_W) : 0;
  localparam int IDX_W   = SEL_W + 1;

  logic [DATA_W-1:0] w_tap [TAPS];
  logic [IDX_W-1:0]  w_idx;
  logic [SUB_W:0]    w_wa;
  logic [SUM_W-1:0]  w_sum;
  logic [SUM_W-1:0]  w_shr;
  logic [DATA_W-1:0] w_res;

  logic [DATA_W-1:0] r_a, r_b;
  logic [SUB_W-1:0]  r_frac;
  logic [SUM_W-1:0]  r_pa, r_pb;
  logic [DATA_W-1:0] r_res;

  always_comb begin
    for (int t = 0; t < TAPS; t++) begin
      w_tap[t] = i_taps[t*DATA_W +: DATA_W];
    end
  end

  generate
    if (SEL_W > 0) begin : g_idx
      assign w_idx = {1'b0, i_pos[SUB_W +: SEL_W]};
    end else begin : g_noidx
      assign w_idx = '0;
    end
  endgenerate

  assign w_wa  = (SUB_W+1)'(WGT_ONE) - {1'b0, r_frac};
  assign w_sum = r_pa + r_pb + SUM_W'(RND);
  assign w_shr = w_sum >> SUB_W;

  // Saturate if anything survives above the data width.
  always_comb begin
    if (|w_shr[SUM_W-1:DATA_W]) begin
      w_res = '1;
    end else begin
      w_res = w_shr[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      r_a    <= w_tap[w_idx];
      r_b    <= w_tap[w_idx + 1'b1];
      r_frac <= i_pos[SUB_W-1:0];
      r_pa   <= SUM_W'(r_a) * SUM_W'(w_wa);
      r_pb   <= SUM_W'(r_b) * SUM_W'(r_frac);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res <= '0;
    end else if (en) begin
      r_res <= w_res;
    end
  end

  assign o_data = r_res;

endmodule

// File: rtl/pix_interp_pipe.sv
// Three-stage multi-channel sub-pixel interpolator with valid/ready back-pressure.
// Owns the valid/last pipes, the global advance and the delivered-beat counter.
module pix_interp_pipe
  import pix_interp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 1,
  parameter int SUB_W  = 5,
  parameter int CH     = 1,
  parameter int ROUND  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [CH*taps_f(SEL_W)*DATA_W-1:0]   in_data,
  input  logic [SEL_W+SUB_W-1:0]               in_pos,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [CH*DATA_W-1:0]                 out_data,
  output logic                                 out_last,
  output logic [15:0]                          out_count
);
  localparam int TAPS = taps_f(SEL_W);

  logic w_adv;
  logic w_xfer;
  logic r_v1, r_v2, r_v3;
  logic r_l1, r_l2, r_l3;
  logic [15:0] r_count;

  // Whole pipe moves as one; bubbles are kept rather than squeezed out.
  assign w_adv    = !r_v3 || out_ready;
  assign w_xfer   = r_v3 && out_ready;
  assign in_ready = w_adv;

  generate
    for (genvar c = 0; c < CH; c++) begin : g_lane
      interp_lane #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W),
        .SUB_W  (SUB_W),
        .ROUND  (ROUND)
      ) u_lane (
        .clk    (clk),
        .rst    (rst),
        .en     (w_adv),
        .i_taps (in_data[c*TAPS*DATA_W +: TAPS*DATA_W]),
        .i_pos  (in_pos),
        .o_data (out_data[c*DATA_W +: DATA_W])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_l1    <= 1'b0;
      r_l2    <= 1'b0;
      r_l3    <= 1'b0;
      r_count <= 16'd0;
    end else begin
      if (w_adv) begin
        r_v1 <= in_valid;
        r_v2 <= r_v1;
        r_v3 <= r_v2;
        r_l1 <= in_last;
        r_l2 <= r_l1;
        r_l3 <= r_l2;
      end
      if (w_xfer) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign out_valid = r_v3;
  assign out_last  = r_l3;
  assign out_count = r_count;

endmodule

// File: tb/tb_pix_interp_pipe.sv
// Directed bench: default config through a scoreboard, plus ROUND=0 and CH=3/SEL_W=2 instances.
module tb_pix_interp_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default configuration
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [23:0] in_data = 24'd0;
  logic [5:0]  in_pos = 6'd0;
  logic        out_valid, out_ready = 1'b1, out_last;
  logic [7:0]  out_data;
  logic [15:0] out_count;

  // ROUND=0
  logic        r0_in_valid = 1'b0, r0_in_ready, r0_out_valid, r0_out_last;
  logic [23:0] r0_in_data = 24'd0;
  logic [5:0]  r0_in_pos = 6'd0;
  logic [7:0]  r0_out_data;
  logic [15:0] r0_out_count;

  // CH=3, SEL_W=2
  logic         c3_in_valid = 1'b0, c3_in_ready, c3_out_valid, c3_out_last;
  logic [119:0] c3_in_data = 120'd0;
  logic [6:0]   c3_in_pos = 7'd0;
  logic [23:0]  c3_out_data;
  logic [15:0]  c3_out_count;

  pix_interp_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_pos(in_pos), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_count(out_count));

  pix_interp_pipe #(.ROUND(0)) u_dut_r0 (
    .clk(clk), .rst(rst), .in_valid(r0_in_valid), .in_ready(r0_in_ready), .in_data(r0_in_data),
    .in_pos(r0_in_pos), .in_last(1'b0), .out_valid(r0_out_valid), .out_ready(1'b1),
    .out_data(r0_out_data), .out_last(r0_out_last), .out_count(r0_out_count));

  pix_interp_pipe #(.CH(3), .SEL_W(2)) u_dut_c3 (
    .clk(clk), .rst(rst), .in_valid(c3_in_valid), .in_ready(c3_in_ready), .in_data(c3_in_data),
    .in_pos(c3_in_pos), .in_last(1'b0), .out_valid(c3_out_valid), .out_ready(1'b1),
    .out_data(c3_out_data), .out_last(c3_out_last), .out_count(c3_out_count));

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, n_sent = 0;
  int   stall_beg = 0, stall_end = 0;
  bit   lat_chk = 1'b0, acc_seen = 1'b0, stall_prev = 1'b0;
  logic [7:0] prev_d = 8'd0;
  logic       prev_l = 1'b0;

  // Reference: blend taps idx/idx+1 by (32-f, f), round-half-up, saturate.
  function automatic logic [7:0] model(input logic [23:0] taps, input logic [5:0] pos);
    int idx, f, a, b, v;
    idx = int'(pos[5]);
    f   = int'(pos[4:0]);
    a   = int'(taps[idx*8 +: 8]);
    b   = int'(taps[(idx+1)*8 +: 8]);
    v   = (a * (32 - f) + b * f + 16) / 32;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard/protocol monitor, sampled on the falling edge.
  task automatic monitor();
    exp_t e;
    if (rst) begin
      stall_prev = 1'b0;
      return;
    end
    check("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
    if (stall_prev && out_valid) begin
      check("stall_data_stable", {23'd0, out_last, out_data}, {23'd0, prev_l, prev_d});
    end
    if (out_valid && out_ready) begin
      n_cmp++;
      assert (q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_beat: observed data %0h expected none", out_data);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        check("out_data", {24'd0, out_data}, {24'd0, e.d});
        check("out_last", {31'd0, out_last}, {31'd0, e.l});
        if (lat_chk) check("latency", 32'(cyc - e.acc), 32'd2);
      end
    end
    if (in_valid && in_ready) begin
      e.d = model(in_data, in_pos);
      e.l = in_last;
      e.acc = cyc + 1;
      q.push_back(e);
      acc_seen = 1'b1;
    end
    stall_prev = out_valid && !out_ready;
    prev_d = out_data;
    prev_l = out_last;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    out_ready = (cyc < stall_beg) || (cyc >= stall_end);
  endtask

  task automatic send(input logic [23:0] taps, input logic [5:0] pos, input logic last);
    int guard;
    in_valid = 1'b1;
    in_data  = taps;
    in_pos   = pos;
    in_last  = last;
    acc_seen = 1'b0;
    guard    = 0;
    while (!acc_seen && guard < 100) begin
      tick();
      guard++;
    end
    if (!acc_seen) check("accept_timeout", 32'd0, 32'd1);
    else n_sent++;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      tick();
      guard++;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int guard;

    repeat (3) tick();
    rst = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_out_count", {16'd0, out_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // taps {10,20,30}: exact endpoints, midpoint and top fraction; latency checked
    lat_chk = 1'b1;
    send(24'h1E140A, 6'd0, 1'b0);  drain();
    send(24'h1E140A, 6'd16, 1'b0); drain();
    send(24'h1E140A, 6'd32, 1'b0); drain();
    send(24'h1E140A, 6'd63, 1'b0); drain();
    send(24'hFFFFFF, 6'd17, 1'b0); drain();
    send(24'h630100, 6'd31, 1'b0); drain();
    send(24'h1E140A, 6'd5, 1'b0);
    send(24'h1E140A, 6'd40, 1'b0);
    send(24'h1E140A, 6'd63, 1'b0);
    drain();
    check("count_after_t1", {16'd0, out_count}, 32'(n_sent));

    // Back-to-back stream with the sink stalled for five cycles
    lat_chk   = 1'b0;
    stall_beg = cyc + 4;
    stall_end = cyc + 9;
    for (int i = 0; i < 8; i++) send(24'hC8_64_05, 6'(i * 8), 1'b0);
    drain();
    stall_beg = 0;
    stall_end = 0;
    check("count_after_t3", {16'd0, out_count}, 32'(n_sent));

    // Last marker on beat 5 of 6
    for (int i = 0; i < 6; i++) send(24'h50_30_10, 6'(i * 11), (i == 4));
    drain();
    check("count_after_t5", {16'd0, out_count}, 32'(n_sent));

    // ROUND=0 truncates where ROUND=1 rounds up
    r0_in_valid = 1'b1;
    r0_in_data  = 24'h630100;
    r0_in_pos   = 6'd31;
    tick();
    r0_in_valid = 1'b0;
    guard = 0;
    while (!r0_out_valid && guard < 10) begin tick(); guard++; end
    check("r0_valid", {31'd0, r0_out_valid}, 32'd1);
    check("r0_trunc", {24'd0, r0_out_data}, 32'd0);

    // Three channels, five taps; idx=3 frac=8 then idx=0 frac=0
    for (int c = 0; c < 3; c++) begin
      for (int t = 0; t < 5; t++) begin
        c3_in_data[(c*5+t)*8 +: 8] = (c == 0) ? 8'(10*t) : (c == 1) ? 8'(100+10*t) : 8'(7+50*t);
      end
    end
    c3_in_valid = 1'b1;
    c3_in_pos   = 7'd104;
    tick();
    c3_in_pos   = 7'd0;
    tick();
    c3_in_valid = 1'b0;
    guard = 0;
    while (!c3_out_valid && guard < 10) begin tick(); guard++; end
    check("c3_idx3_frac8", {8'd0, c3_out_data}, 32'hAA8521);
    tick();
    check("c3_idx0_frac0", {8'd0, c3_out_data}, 32'h076400);
    check("c3_count", {16'd0, c3_out_count}, 32'd1);

    // Mid-stream reset with three beats in flight
    out_ready = 1'b0;
    stall_beg = 0;
    stall_end = 1 << 30;
    for (int i = 0; i < 3; i++) send(24'h1E140A, 6'(i * 9), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    n_sent = 0;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_count", {16'd0, out_count}, 32'd0);
    stall_end = 0;
    out_ready = 1'b1;
    repeat (8) tick();
    check("midrst_no_emit", {16'd0, out_count}, 32'd0);

    // Counter wrap: 65535 beats to 0xFFFF, one more to 0
    for (int i = 0; i < 65535; i++) send(24'hF0_80_11, 6'($urandom_range(0, 63)), 1'b0);
    drain();
    check("count_ffff", {16'd0, out_count}, 32'h0000FFFF);
    send(24'hF0_80_11, 6'd7, 1'b0);
    drain();
    check("count_wrap", {16'd0, out_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
